// File: rtl/load_store_unit.sv
// RV32 load/store unit: one outstanding access, byte-lane steering, load extension and a bus timeout.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses answer with an error instead of being aligned down.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       SZ_BYTE  = 2'd0;
    localparam logic [1:0]       SZ_HALF  = 2'd1;
    localparam logic [1:0]       SZ_WORD  = 2'd2;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_in, off_in, size_q, off_q;
    logic             unsigned_in, unsigned_q, trap_in;
    logic             accept, timeout;
    logic [3:0]       be_in;
    logic [31:0]      wdata_in, lane, load_ext;

    assign req_ready  = (state == IDLE);
    assign mem_req    = (state == REQ);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && (state == IDLE);
    assign timeout    = (cnt == CNT_LAST);

    // Request decode; stores only know SB/SH/SW, anything else is a word access.
    always_comb begin
        size_in     = SZ_WORD;
        unsigned_in = 1'b0;
        if (is_store) begin
            if (funct3 == 3'b000)      size_in = SZ_BYTE;
            else if (funct3 == 3'b001) size_in = SZ_HALF;
        end else begin
            case (funct3)
                3'b000, 3'b100: size_in = SZ_BYTE;
                3'b001, 3'b101: size_in = SZ_HALF;
                default:        size_in = SZ_WORD;
            endcase
            unsigned_in = (funct3 == 3'b100) || (funct3 == 3'b101);
        end

        case (size_in)
            SZ_BYTE: off_in = addr[1:0];
            SZ_HALF: off_in = {addr[1], 1'b0};
            default: off_in = 2'b00;
        endcase

`ifdef MISALIGN_TRAP_EN
        trap_in = ((size_in == SZ_HALF) && addr[0]) ||
                  ((size_in == SZ_WORD) && (addr[1:0] != 2'b00));
`else
        trap_in = 1'b0;
`endif

        case (size_in)
            SZ_BYTE: begin
                be_in    = 4'b0001 << off_in;
                wdata_in = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be_in    = 4'b0011 << off_in;
                wdata_in = {2{wdata[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = wdata;
            end
        endcase
    end

    always_comb begin
        lane = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            SZ_BYTE: load_ext = unsigned_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            SZ_HALF: load_ext = unsigned_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = trap_in ? RESP : REQ;
            REQ:  if (mem_ack || timeout) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            size_q     <= SZ_BYTE;
            off_q      <= 2'b00;
            unsigned_q <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
        end else begin
            cnt <= (state == REQ && !mem_ack) ? cnt + 1'b1 : '0;
            if (accept) begin
                mem_we     <= is_store;
                mem_addr   <= {addr[31:2], 2'b00};
                mem_wdata  <= wdata_in;
                mem_be     <= be_in;
                size_q     <= size_in;
                off_q      <= off_in;
                unsigned_q <= unsigned_in;
                resp_rd    <= rd_in;
                resp_err   <= trap_in;
                resp_data  <= '0;
            end else if (state == REQ) begin
                // An ack arriving on the timeout cycle still counts as success.
                if (mem_ack) begin
                    resp_err  <= 1'b0;
                    resp_data <= mem_we ? 32'd0 : load_ext;
                end else if (timeout) begin
                    resp_err  <= 1'b1;
                    resp_data <= '0;
                end
            end
        end
    end
endmodule
